// File: rtl/instr_encode_loader.sv
// Packs opcode/register/operand field sets into 16-bit instruction words and
// streams them to consecutive imem addresses. Optional macro: INSTR_ENC_CHECKSUM_EN.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic              in_last,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_src_addr1,
  input  logic [3:0]        in_src_addr2,
  input  logic [3:0]        in_dest_addr,
  input  logic [11:0]       in_operand,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              truncated,
  output logic [ADDR_W:0]   count,
  output logic [15:0]       checksum
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Pointer arithmetic is modulo 2**ADDR_W, so the last slot may sit below the base.
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BASE_ADDR + DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              truncated_q, truncated_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        full;
  logic        load_entry;
  logic [15:0] packed_word;

  assign accept = in_valid && (state_q == ST_LOAD);
  assign full   = (ptr_q == LAST_PTR);
  assign packed_word = in_fmt ? {in_opcode, in_operand}
                              : {in_opcode, in_src_addr1, in_src_addr2, in_dest_addr};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    truncated_d = truncated_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_entry  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_entry  = 1'b1;
          state_d     = ST_LOAD;
          ptr_d       = BASE_PTR;
          count_d     = '0;
          truncated_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = packed_word;
          ptr_d       = ptr_q + 1'b1;
          count_d     = count_q + 1'b1;
          if (in_last || full) begin
            state_d     = ST_DONE;
            truncated_d = full && !in_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= BASE_PTR;
      count_q     <= '0;
      truncated_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      truncated_q <= truncated_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Folded in at the accept edge so it already includes the word on the bus.
  always_comb begin
    checksum_d = checksum_q;
    if (load_entry)  checksum_d = '0;
    else if (accept) checksum_d = checksum_q ^ packed_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign truncated = truncated_q;
  assign count     = count_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (DEPTH=4 so truncation is reachable):
// a vector table for packing/back-to-back/full plus hand sequences for corner cases.
module tb_instr_encode_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_fmt;
  logic              in_last;
  logic [3:0]        in_opcode;
  logic [3:0]        in_src_addr1;
  logic [3:0]        in_src_addr2;
  logic [3:0]        in_dest_addr;
  logic [11:0]       in_operand;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              truncated;
  logic [ADDR_W:0]   count;
  logic [15:0]       checksum;

  int errors = 0;
  int checks = 0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_last(in_last), .in_opcode(in_opcode),
    .in_src_addr1(in_src_addr1), .in_src_addr2(in_src_addr2),
    .in_dest_addr(in_dest_addr), .in_operand(in_operand),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .truncated(truncated), .count(count),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fmt;
    logic        last;
    logic [3:0]  op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  d;
    logic [11:0] operand;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fmt, input logic last, input logic [3:0] op,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [11:0] operand);
    in_valid     = 1'b1;
    in_fmt       = fmt;
    in_last      = last;
    in_opcode    = op;
    in_src_addr1 = s1;
    in_src_addr2 = s2;
    in_dest_addr = d;
    in_operand   = operand;
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef INSTR_ENC_CHECKSUM_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    logic [15:0] ck_model;

    vecs[0] = '{1'b1, 1'b0, 4'h9, 4'hF, 4'hF, 4'hF, 12'hABC, 1'b1, 8'd0, 16'h9ABC};
    vecs[1] = '{1'b0, 1'b0, 4'h3, 4'h1, 4'h2, 4'h4, 12'hFFF, 1'b1, 8'd1, 16'h3124};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 12'hFFF, 1'b1, 8'd2, 16'h0FFF};
    vecs[3] = '{1'b0, 1'b0, 4'hF, 4'hA, 4'h5, 4'h0, 12'h123, 1'b1, 8'd3, 16'hFA50};
    vecs[4] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 12'h123, 1'b0, 8'd3, 16'hFA50};
    vecs[5] = '{1'b0, 1'b0, 4'h7, 4'h7, 4'h7, 4'h7, 12'h000, 1'b0, 8'd3, 16'hFA50};

    rst = 1'b1; start = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state, then in_valid in IDLE must not write.
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_truncated", truncated, 0);
    check("rst_count", count, 0);
    check("rst_checksum", checksum, 0);
    drive(1'b0, 1'b1, 4'h3, 4'h1, 4'h2, 4'h4, 12'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_write", mem_we, 0);
    end
    in_valid = 1'b0;

    // Single reg-form word with last.
    do_start();
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 1);
    drive(1'b0, 1'b1, 4'h3, 4'h1, 4'h2, 4'h4, 12'hFFF);
    step();
    in_valid = 1'b0;
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 0);
    check("single_wdata", mem_wdata, 16'h3124);
    check("single_done", done, 1);
    check("single_count", count, 1);
    check("single_trunc", truncated, 0);
    check("single_ck", checksum, exp_ck(16'h3124));
    step();
    check("single_we_drop", mem_we, 0);
    check("single_hold_wdata", mem_wdata, 16'h3124);
    drive(1'b1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 12'h111);
    step();
    check("done_ignores_valid", mem_we, 0);
    in_valid = 1'b0;

    // Table: packing, back-to-back writes, then truncation at DEPTH.
    do_start();
    check("restart_count", count, 0);
    check("restart_done", done, 0);
    check("restart_ck", checksum, 0);
    ck_model = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].fmt, vecs[i].last, vecs[i].op, vecs[i].s1, vecs[i].s2,
            vecs[i].d, vecs[i].operand);
      step();
      if (vecs[i].exp_we) ck_model = ck_model ^ vecs[i].exp_wdata;
      check($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_done", done, 1);
    check("full_trunc", truncated, 1);
    check("full_count", count, 4);
    check("full_ck", checksum, exp_ck(ck_model));

    // Gap cycle, start ignored in LOAD, checksum of two words.
    do_start();
    check("after_trunc_clear", truncated, 0);
    drive(1'b0, 1'b0, 4'h3, 4'h1, 4'h2, 4'h4, 12'h000);
    step();
    in_valid = 1'b0;
    check("gap_w0_addr", mem_addr, 0);
    step();
    check("gap_no_write", mem_we, 0);
    check("gap_hold_addr", mem_addr, 0);
    start = 1'b1;
    drive(1'b1, 1'b1, 4'h9, 4'h0, 4'h0, 4'h0, 12'hABC);
    step();
    start = 1'b0; in_valid = 1'b0;
    check("start_in_load_addr", mem_addr, 1);
    check("start_in_load_wdata", mem_wdata, 16'h9ABC);
    check("two_count", count, 2);
    check("two_ck", checksum, exp_ck(16'hAB98));
    step();
    check("done_holds_ck", checksum, exp_ck(16'hAB98));

    // in_last on the full slot is a clean finish, not a truncation.
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3), 4'h2, 4'h0, 4'h0, 4'h0, 12'(i));
      step();
    end
    in_valid = 1'b0;
    check("last_on_full_addr", mem_addr, 3);
    check("last_on_full_done", done, 1);
    check("last_on_full_trunc", truncated, 0);
    check("last_on_full_count", count, 4);

    // Reset mid-load drops the pending write; reload starts from base.
    do_start();
    drive(1'b0, 1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 12'h0);
    step();
    check("pre_rst_we", mem_we, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_ck", checksum, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst_mid_idle_ready", in_ready, 0);
    do_start();
    drive(1'b0, 1'b1, 4'hC, 4'h0, 4'hD, 4'hE, 12'h0);
    step();
    in_valid = 1'b0;
    check("reload_addr", mem_addr, 0);
    check("reload_wdata", mem_wdata, 16'hC0DE);
    check("reload_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
